// File: rtl/dmem_dma.sv
// Block copy / block fill engine that masters the single-port data memory.
// Outputs come from registers loaded by the state being left; m_din bypasses from m_dout on copy writes.
module dmem_dma #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic          m_we,
  input  logic [DW-1:0] m_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t state_reg, state_next;

  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [AW-1:0] len_reg, len_next;
  logic [DW-1:0] fill_reg, fill_next;
  logic [AW-1:0] idx_reg, idx_next;

  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [AW-1:0] count_reg, count_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] din_reg, din_next;
  logic          we_reg, we_next;
  logic          fwd_reg, fwd_next;

  logic [AW-1:0] last_idx;
  logic          last;
  logic          kill;

  // Full-width compare so len = all-ones is a legal transfer length.
  assign last_idx = len_reg - ONE;
  assign last     = (idx_reg == last_idx);
  assign kill     = (state_reg != S_IDLE) && abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = S_FIN;
          end else if (mode) begin
            state_next = S_FILL;
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_RD:    state_next = S_WR;
      S_WR:    state_next = last ? S_FIN : S_RD;
      S_FILL:  state_next = last ? S_FIN : S_FILL;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (kill) begin
      state_next = S_IDLE;
    end
  end

  // Output / datapath next values
  always_comb begin
    src_next   = src_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    fill_next  = fill_reg;
    idx_next   = idx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    count_next = count_reg;
    addr_next  = '0;
    din_next   = '0;
    we_next    = 1'b0;
    fwd_next   = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          src_next   = src;
          dst_next   = dst;
          len_next   = len;
          fill_next  = fill_val;
          idx_next   = '0;
          count_next = '0;
          busy_next  = 1'b1;
        end
      end
      S_RD: begin
        addr_next = src_reg + idx_reg;
      end
      S_WR: begin
        addr_next  = dst_reg + idx_reg;
        we_next    = 1'b1;
        fwd_next   = 1'b1;
        count_next = count_reg + ONE;
        if (!last) begin
          idx_next = idx_reg + ONE;
        end
      end
      S_FILL: begin
        addr_next  = dst_reg + idx_reg;
        din_next   = fill_reg;
        we_next    = 1'b1;
        count_next = count_reg + ONE;
        if (!last) begin
          idx_next = idx_reg + ONE;
        end
      end
      S_FIN: begin
        done_next = 1'b1;
        busy_next = 1'b0;
      end
      default: begin
        busy_next = 1'b0;
      end
    endcase
    // The write already on the bus completes; the one being queued is dropped.
    if (kill) begin
      idx_next   = idx_reg;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      count_next = count_reg;
      addr_next  = '0;
      din_next   = '0;
      we_next    = 1'b0;
      fwd_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      fill_reg  <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= '0;
      addr_reg  <= '0;
      din_reg   <= '0;
      we_reg    <= 1'b0;
      fwd_reg   <= 1'b0;
    end else begin
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      fill_reg  <= fill_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      we_reg    <= we_next;
      fwd_reg   <= fwd_next;
    end
  end

  // Read data only arrives in the write cycle, so copy writes take it straight from m_dout.
  assign m_din  = fwd_reg ? m_dout : din_reg;
  assign m_addr = addr_reg;
  assign m_we   = we_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign count  = count_reg;

endmodule
